// File: rtl/frame_feeder.sv
// frame_feeder: holds one grayscale frame in block RAM and streams it in raster order on go.
// Optional FEEDER_LINE_GAP_EN inserts LINE_GAP idle cycles between consecutive rows.
module frame_feeder #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int START_GAP  = 2,
    parameter int LINE_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       go,
    input  logic       pause,
    input  logic       downstream_done,
    output logic       start_signal,
    output logic       pixel_valid_out,
    output logic [7:0] pixel_out,
    output logic       busy,
    output logic       frame_done,
    output logic       wr_err
);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;

`ifdef FEEDER_LINE_GAP_EN
    typedef enum logic [2:0] {IDLE, START, GAP, STREAM, LGAP, DRAIN, WAIT_DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, GAP, STREAM, DRAIN, WAIT_DONE} state_t;
`endif

    (* ram_style = "block" *) logic [7:0] mem [1024];

    state_t      state, state_nx;
    logic [9:0]  addr, col, row;
    logic [15:0] gap_cnt;
    logic        issue, last_col, last_pix, go_ok, wr_ok;
`ifdef FEEDER_LINE_GAP_EN
    logic [15:0] lgap_cnt;
`endif

    assign go_ok        = state == IDLE && go;
    assign wr_ok        = wr_en && state == IDLE && {1'b0, wr_addr} < 11'(TOTAL);
    assign issue        = state == STREAM && !pause;
    assign last_col     = col == 10'(IMG_WIDTH - 1);
    assign last_pix     = last_col && row == 10'(IMG_HEIGHT - 1);
    assign start_signal = state == START;
    assign busy         = state != IDLE;

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_addr] <= wr_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (go) state_nx = START;
            START:     state_nx = START_GAP == 0 ? STREAM : GAP;
            GAP:       if (gap_cnt == 16'(START_GAP - 1)) state_nx = STREAM;
            STREAM:    if (issue && last_pix) state_nx = DRAIN;
`ifdef FEEDER_LINE_GAP_EN
                       else if (issue && last_col && LINE_GAP > 0) state_nx = LGAP;
            LGAP:      if (lgap_cnt == 16'(LINE_GAP - 1)) state_nx = STREAM;
`endif
            DRAIN:     state_nx = WAIT_DONE;
            WAIT_DONE: if (downstream_done) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // pixel_out only loads on an issued read, so it holds between valid pixels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr            <= 10'd0;
            col             <= 10'd0;
            row             <= 10'd0;
            gap_cnt         <= 16'd0;
            pixel_valid_out <= 1'b0;
            pixel_out       <= 8'h00;
            frame_done      <= 1'b0;
            wr_err          <= 1'b0;
        end else begin
            gap_cnt         <= state == GAP ? gap_cnt + 16'd1 : 16'd0;
            pixel_valid_out <= issue;
            frame_done      <= state == WAIT_DONE && downstream_done;
            wr_err          <= (wr_err && !go_ok) || (wr_en && !wr_ok);
            if (issue) begin
                pixel_out <= mem[addr];
                addr      <= last_pix ? 10'd0 : addr + 10'd1;
                col       <= last_col ? 10'd0 : col + 10'd1;
                row       <= last_pix ? 10'd0 : last_col ? row + 10'd1 : row;
            end
        end
    end

`ifdef FEEDER_LINE_GAP_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) lgap_cnt <= 16'd0;
        else      lgap_cnt <= state == LGAP ? lgap_cnt + 16'd1 : 16'd0;
`endif
endmodule

// File: tb/tb_frame_feeder.sv
// tb_frame_feeder: scoreboard bench; expected pixels are queued at go, a monitor checks each valid pixel.
module tb_frame_feeder;
    localparam int W = 32, H = 32, N = W * H;
`ifdef FEEDER_LINE_GAP_EN
    localparam int LG = 4;
`else
    localparam int LG = 0;
`endif
    localparam int DONE_CYC = LG > 0 ? 1200 : 1100;

    logic       clk = 0, rst = 0, wr_en = 0, go = 0, pause = 0, downstream_done = 0;
    logic [9:0] wr_addr = 0;
    logic [7:0] wr_data = 0;
    logic       start_signal, pixel_valid_out, busy, frame_done, wr_err;
    logic [7:0] pixel_out;
    logic       s_wr_en = 0, s_zero = 0;
    logic [9:0] s_wr_addr = 0;
    logic       s_start, s_valid, s_busy, s_done, s_wr_err;
    logic [7:0] s_pixel;

    frame_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .pause(pause), .downstream_done(downstream_done),
        .start_signal(start_signal), .pixel_valid_out(pixel_valid_out), .pixel_out(pixel_out),
        .busy(busy), .frame_done(frame_done), .wr_err(wr_err)
    );

    frame_feeder #(.IMG_HEIGHT(16)) u_small (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(wr_data),
        .go(s_zero), .pause(s_zero), .downstream_done(s_zero),
        .start_signal(s_start), .pixel_valid_out(s_valid), .pixel_out(s_pixel),
        .busy(s_busy), .frame_done(s_done), .wr_err(s_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] v; int c; } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0, g = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (pixel_valid_out) begin
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL pixel_unexpected: got %02h at cycle %0d, required no pixel", pixel_out, cyc - g + 1);
        end else begin
            e = q.pop_front();
            if (pixel_out !== e.v || cyc - g + 1 != e.c) begin
                errors++;
                $display("FAIL pixel: got %02h at cycle %0d, required %02h at cycle %0d",
                         pixel_out, cyc - g + 1, e.v, e.c);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int n);
        while (cyc - g + 1 < n) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    // expected cycle of pixel i: first at cycle 5, shifted by row gaps and an optional 5-cycle pause at cycle 10
    task automatic push_frame(input bit paused, input int lim);
        int c;
        for (int i = 0; i < N; i++) begin
            c = 5 + i + LG * (i / W);
            if (paused && c > 10) c += 5;
            if (c < lim) q.push_back('{v: 8'(i), c: c});
        end
    endtask

    task automatic launch();
        go = 1;
        @(posedge clk);
        #1;
        g = cyc;
        go = 0;
    endtask

    task automatic finish_frame(input bit with_go);
        at_cycle(DONE_CYC);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("busy_wait_done", busy, 1);
        chk("frame_done_early", frame_done, 0);
        downstream_done = 1;
        go = with_go;
        tick();
        downstream_done = 0;
        go = 0;
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 1);
        chk("busy_fall", busy, 0);
        tick();
        @(negedge clk);
        chk("frame_done_end", frame_done, 0);
        chk("idle_no_start", start_signal, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        tick();
        tick();
        @(negedge clk);
        chk("rst_start", start_signal, 0);
        chk("rst_valid", pixel_valid_out, 0);
        chk("rst_pixel", pixel_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wr_err", wr_err, 0);
        tick();
        rst = 1;
        tick();

        s_wr_en = 1; s_wr_addr = 10'd511; wr_data = 8'h3C;
        tick();
        @(negedge clk);
        chk("small_in_range_wr_err", s_wr_err, 0);
        s_wr_addr = 10'd1023;
        tick();
        s_wr_en = 0;
        @(negedge clk);
        chk("small_out_of_range_wr_err", s_wr_err, 1);
        tick();

        for (int k = 0; k < N; k++) begin
            wr_en = 1; wr_addr = 10'(k); wr_data = 8'(k);
            tick();
        end
        wr_en = 0;
        @(negedge clk);
        chk("load_wr_err", wr_err, 0);
        tick();

        push_frame(0, 1 << 30);
        launch();
        @(negedge clk);
        chk("f1_start_c1", start_signal, 1);
        chk("f1_busy_c1", busy, 1);
        tick();
        @(negedge clk);
        chk("f1_start_c2", start_signal, 0);
        finish_frame(0);

        tick();
        push_frame(0, 1 << 30);
        launch();
        at_cycle(2);
        downstream_done = 1;
        tick();
        downstream_done = 0;
        at_cycle(100);
        go = 1; wr_en = 1; wr_addr = 10'd5; wr_data = 8'hAA;
        tick();
        go = 0; wr_en = 0;
        @(negedge clk);
        chk("f2_drop_wr_err", wr_err, 1);
        chk("f2_busy_after_go", busy, 1);
        finish_frame(1);
        chk("f2_wr_err_kept", wr_err, 1);

        tick();
        push_frame(1, 1 << 30);
        launch();
        @(negedge clk);
        chk("f3_wr_err_cleared", wr_err, 0);
        at_cycle(10);
        pause = 1;
        at_cycle(15);
        pause = 0;
        finish_frame(0);

        tick();
        push_frame(0, 300);
        launch();
        at_cycle(300);
        rst = 0;
        tick();
        rst = 1;
        @(negedge clk);
        chk("abort_queue", q.size(), 0);
        chk("abort_start", start_signal, 0);
        chk("abort_valid", pixel_valid_out, 0);
        chk("abort_pixel", pixel_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_frame_done", frame_done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("abort_stays_idle", {busy, frame_done}, 0);
        end

        tick();
        push_frame(0, 1 << 30);
        launch();
        finish_frame(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
